// File: rtl/attr_pkg.sv
// Shared definitions for the attribute span walker.
// Q-format defaults, walker states and saturation limits.
package attr_pkg;

  localparam int ATTR_INT  = 16;
  localparam int ATTR_FRAC = 16;
  localparam int ATTR_QW   = ATTR_INT + ATTR_FRAC;
  localparam int ATTR_XYW  = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_WALK  = 2'd2
  } walk_state_t;

  localparam logic signed [ATTR_QW-1:0] ATTR_Q_MAX =
    {1'b0, {(ATTR_QW-1){1'b1}}};
  localparam logic signed [ATTR_QW-1:0] ATTR_Q_MIN =
    {1'b1, {(ATTR_QW-1){1'b0}}};

endpackage

// File: rtl/attr_setup_mac.sv
// Combinational start-value evaluator for the span walker.
// Evaluates the attribute plane at the centre of the first pixel.
module attr_setup_mac
  import attr_pkg::*;
#(
  parameter int INT  = ATTR_INT,
  parameter int FRAC = ATTR_FRAC,
  parameter int XYW  = ATTR_XYW
) (
  input  logic signed [INT+FRAC-1:0] i_p_ref,
  input  logic signed [INT+FRAC-1:0] i_x_ref,
  input  logic signed [INT+FRAC-1:0] i_y_ref,
  input  logic signed [INT+FRAC-1:0] i_dpdx,
  input  logic signed [INT+FRAC-1:0] i_dpdy,
  input  logic        [XYW-1:0]      i_xmin,
  input  logic        [XYW-1:0]      i_ymin,
  output logic signed [INT+FRAC-1:0] o_p_start
);

  localparam int QW = INT + FRAC;
  localparam int DW = QW + 1;
  localparam int PW = 2 * QW + 2;
  localparam int SW = PW + 1;

  localparam logic signed [QW-1:0] L_MAX =
    {1'b0, {(QW-1){1'b1}}};
  localparam logic signed [QW-1:0] L_MIN =
    {1'b1, {(QW-1){1'b0}}};

  logic        [DW-1:0] w_xc_u;
  logic        [DW-1:0] w_yc_u;
  logic signed [DW-1:0] w_dx;
  logic signed [DW-1:0] w_dy;
  logic signed [DW-1:0] w_gx;
  logic signed [DW-1:0] w_gy;
  logic signed [PW-1:0] w_pdx;
  logic signed [PW-1:0] w_pdy;
  logic signed [SW-1:0] w_pref;
  logic signed [SW-1:0] w_sum;
  logic signed [SW-1:0] w_shr;

  // Pixel centre: coord in the integer field, one half below.
  assign w_xc_u = DW'({i_xmin, 1'b1, {(FRAC-1){1'b0}}});
  assign w_yc_u = DW'({i_ymin, 1'b1, {(FRAC-1){1'b0}}});

  assign w_dx = $signed(w_xc_u) - DW'(i_x_ref);
  assign w_dy = $signed(w_yc_u) - DW'(i_y_ref);
  assign w_gx = DW'(i_dpdx);
  assign w_gy = DW'(i_dpdy);

  assign w_pdx = PW'(w_dx) * PW'(w_gx);
  assign w_pdy = PW'(w_dy) * PW'(w_gy);

  assign w_pref = SW'(i_p_ref) <<< FRAC;
  assign w_sum  = w_pref + SW'(w_pdx) + SW'(w_pdy);
  assign w_shr  = w_sum >>> FRAC;

  // Clamp the floored sum into the signed Q range.
  always_comb begin
    o_p_start = w_shr[QW-1:0];
    if (w_shr > SW'(L_MAX)) begin
      o_p_start = L_MAX;
    end else if (w_shr < SW'(L_MIN)) begin
      o_p_start = L_MIN;
    end
  end

endmodule

// File: rtl/attr_span_walker.sv
// Raster walker: steps an attribute across a triangle's bbox.
// One pixel beat per cycle, with valid/ready back-pressure.
module attr_span_walker
  import attr_pkg::*;
#(
  parameter int INT  = ATTR_INT,
  parameter int FRAC = ATTR_FRAC,
  parameter int XYW  = ATTR_XYW
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [INT+FRAC-1:0] p_ref,
  input  logic signed [INT+FRAC-1:0] x_ref,
  input  logic signed [INT+FRAC-1:0] y_ref,
  input  logic signed [INT+FRAC-1:0] dpdx,
  input  logic signed [INT+FRAC-1:0] dpdy,
  input  logic                       grad_ok,
  input  logic        [XYW-1:0]      bb_xmin,
  input  logic        [XYW-1:0]      bb_xmax,
  input  logic        [XYW-1:0]      bb_ymin,
  input  logic        [XYW-1:0]      bb_ymax,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic        [XYW-1:0]      out_x,
  output logic        [XYW-1:0]      out_y,
  output logic signed [INT+FRAC-1:0] out_p,
  output logic                       out_last,
  output logic                       busy,
  output logic                       drop
);

  localparam int QW = INT + FRAC;

  walk_state_t r_state;

  logic signed [QW-1:0]  r_pref;
  logic signed [QW-1:0]  r_xref;
  logic signed [QW-1:0]  r_yref;
  logic signed [QW-1:0]  r_dpdx;
  logic signed [QW-1:0]  r_dpdy;
  logic        [XYW-1:0] r_xmin;
  logic        [XYW-1:0] r_xmax;
  logic        [XYW-1:0] r_ymin;
  logic        [XYW-1:0] r_ymax;
  logic                  r_bad;

  logic        [XYW-1:0] r_x;
  logic        [XYW-1:0] r_y;
  logic signed [QW-1:0]  r_p;
  logic signed [QW-1:0]  r_prow;
  logic                  r_ovalid;
  logic                  r_last;
  logic                  r_drop;

  logic                  w_accept;
  logic                  w_beat;
  logic                  w_bad_in;
  logic                  w_x_end;
  logic        [XYW-1:0] w_xn;
  logic        [XYW-1:0] w_yn;
  logic signed [QW-1:0]  w_pstart;
  logic signed [QW-1:0]  w_prow_n;

  assign in_ready  = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign out_valid = r_ovalid;
  assign out_x     = r_x;
  assign out_y     = r_y;
  assign out_p     = r_p;
  assign out_last  = r_last;
  assign drop      = r_drop;

  assign w_accept = in_valid & in_ready;
  assign w_beat   = r_ovalid & out_ready;
  assign w_bad_in = ~grad_ok
                  | (bb_xmin > bb_xmax)
                  | (bb_ymin > bb_ymax);
  assign w_x_end  = (r_x == r_xmax);
  assign w_xn     = r_x + XYW'(1);
  assign w_yn     = r_y + XYW'(1);
  assign w_prow_n = r_prow + r_dpdy;

  attr_setup_mac #(
    .INT (INT),
    .FRAC(FRAC),
    .XYW (XYW)
  ) u_mac (
    .i_p_ref  (r_pref),
    .i_x_ref  (r_xref),
    .i_y_ref  (r_yref),
    .i_dpdx   (r_dpdx),
    .i_dpdy   (r_dpdy),
    .i_xmin   (r_xmin),
    .i_ymin   (r_ymin),
    .o_p_start(w_pstart)
  );

  // Walker FSM: capture, setup/reject, then raster stepping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_pref   <= '0;
      r_xref   <= '0;
      r_yref   <= '0;
      r_dpdx   <= '0;
      r_dpdy   <= '0;
      r_xmin   <= '0;
      r_xmax   <= '0;
      r_ymin   <= '0;
      r_ymax   <= '0;
      r_bad    <= 1'b0;
      r_x      <= '0;
      r_y      <= '0;
      r_p      <= '0;
      r_prow   <= '0;
      r_ovalid <= 1'b0;
      r_last   <= 1'b0;
      r_drop   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_pref  <= p_ref;
            r_xref  <= x_ref;
            r_yref  <= y_ref;
            r_dpdx  <= dpdx;
            r_dpdy  <= dpdy;
            r_xmin  <= bb_xmin;
            r_xmax  <= bb_xmax;
            r_ymin  <= bb_ymin;
            r_ymax  <= bb_ymax;
            r_bad   <= w_bad_in;
            r_drop  <= w_bad_in;
            r_state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          r_drop <= 1'b0;
          if (r_bad) begin
            r_state <= ST_IDLE;
          end else begin
            r_x      <= r_xmin;
            r_y      <= r_ymin;
            r_p      <= w_pstart;
            r_prow   <= w_pstart;
            r_ovalid <= 1'b1;
            r_last   <= (r_xmin == r_xmax)
                      && (r_ymin == r_ymax);
            r_state  <= ST_WALK;
          end
        end
        ST_WALK: begin
          if (w_beat) begin
            if (r_last) begin
              r_ovalid <= 1'b0;
              r_last   <= 1'b0;
              r_state  <= ST_IDLE;
            end else if (w_x_end) begin
              r_x    <= r_xmin;
              r_y    <= w_yn;
              r_p    <= w_prow_n;
              r_prow <= w_prow_n;
              r_last <= (r_xmin == r_xmax)
                      && (w_yn == r_ymax);
            end else begin
              r_x    <= w_xn;
              r_p    <= r_p + r_dpdx;
              r_last <= (w_xn == r_xmax)
                      && (r_y == r_ymax);
            end
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_ovalid <= 1'b0;
          r_last   <= 1'b0;
          r_drop   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_attr_span_walker.sv
// Directed bench for attr_span_walker.
// Hand-computed pixel sequences, stall, drop and reset cases.
module tb_attr_span_walker;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [31:0] p_ref;
  logic signed [31:0] x_ref;
  logic signed [31:0] y_ref;
  logic signed [31:0] dpdx;
  logic signed [31:0] dpdy;
  logic               grad_ok;
  logic        [11:0] bb_xmin;
  logic        [11:0] bb_xmax;
  logic        [11:0] bb_ymin;
  logic        [11:0] bb_ymax;
  logic               out_valid;
  logic               out_ready;
  logic        [11:0] out_x;
  logic        [11:0] out_y;
  logic signed [31:0] out_p;
  logic               out_last;
  logic               busy;
  logic               drop;

  int errors;
  int checks;

  logic [11:0] e_x[6];
  logic [11:0] e_y[6];
  logic [31:0] e_p[6];

  attr_span_walker dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .p_ref    (p_ref),
    .x_ref    (x_ref),
    .y_ref    (y_ref),
    .dpdx     (dpdx),
    .dpdy     (dpdy),
    .grad_ok  (grad_ok),
    .bb_xmin  (bb_xmin),
    .bb_xmax  (bb_xmax),
    .bb_ymin  (bb_ymin),
    .bb_ymax  (bb_ymax),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_x    (out_x),
    .out_y    (out_y),
    .out_p    (out_p),
    .out_last (out_last),
    .busy     (busy),
    .drop     (drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Offer one triangle; returns just after the accepting edge.
  task automatic start_tri(
    input logic [31:0] pr, xr, yr, gx, gy,
    input logic        g,
    input logic [11:0] x0, x1, y0, y1
  );
    @(negedge clk);
    p_ref = pr; x_ref = xr; y_ref = yr;
    dpdx = gx; dpdy = gy; grad_ok = g;
    bb_xmin = x0; bb_xmax = x1;
    bb_ymin = y0; bb_ymax = y1;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic start_basic();
    start_tri(32'h0, 32'h0, 32'h0,
              32'h0001_0000, 32'h0002_0000, 1'b1,
              12'd0, 12'd2, 12'd0, 12'd1);
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 ||
        drop !== 1'b0 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: v=%b b=%b d=%b l=%b want 0",
               out_valid, busy, drop, out_last);
    end
    checks++;
    if (out_p !== 32'h0 || out_x !== 12'h0 ||
        out_y !== 12'h0) begin
      errors++;
      $display("FAIL reset_data: p=%h x=%0d y=%0d want 0",
               out_p, out_x, out_y);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_basic();
    start_basic();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b1 ||
        in_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_setup: v=%b b=%b r=%b want 0 1 0",
               out_valid, busy, in_ready);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_x !== e_x[k] ||
          out_y !== e_y[k] || out_p !== e_p[k] ||
          out_last !== (k == 5)) begin
        errors++;
        $display("FAIL basic_beat%0d: v=%b (%0d,%0d) p=%h l=%b want (%0d,%0d) p=%h l=%b",
                 k, out_valid, out_x, out_y, out_p, out_last,
                 e_x[k], e_y[k], e_p[k], (k == 5));
      end
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 ||
        busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_end: v=%b r=%b b=%b want 0 1 0",
               out_valid, in_ready, busy);
    end
  endtask

  task automatic test_stall();
    int k;
    int stalls;
    k = 0;
    stalls = 0;
    start_basic();
    @(negedge clk);
    for (int c = 0; c < 20 && k < 6; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_x !== e_x[k] ||
          out_y !== e_y[k] || out_p !== e_p[k] ||
          out_last !== (k == 5)) begin
        errors++;
        $display("FAIL stall_beat%0d: v=%b (%0d,%0d) p=%h l=%b want (%0d,%0d) p=%h",
                 k, out_valid, out_x, out_y, out_p, out_last,
                 e_x[k], e_y[k], e_p[k]);
      end
      if (k == 2 && stalls < 3) begin
        out_ready = 1'b0;
        stalls++;
      end else begin
        out_ready = 1'b1;
        k++;
      end
    end
    out_ready = 1'b1;
    checks++;
    if (k != 6 || stalls != 3) begin
      errors++;
      $display("FAIL stall_count: beats=%0d stalls=%0d want 6 3",
               k, stalls);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_end: v=%b r=%b want 0 1",
               out_valid, in_ready);
    end
  endtask

  task automatic test_drop(input logic g,
                           input logic [11:0] x0, x1);
    int seen;
    seen = 0;
    start_tri(32'h0, 32'h0, 32'h0,
              32'h0001_0000, 32'h0, g,
              x0, x1, 12'd0, 12'd0);
    @(negedge clk);
    checks++;
    if (drop !== 1'b1 || out_valid !== 1'b0 ||
        in_ready !== 1'b0) begin
      errors++;
      $display("FAIL drop_pulse: d=%b v=%b r=%b want 1 0 0",
               drop, out_valid, in_ready);
    end
    @(negedge clk);
    checks++;
    if (drop !== 1'b0 || in_ready !== 1'b1 ||
        busy !== 1'b0) begin
      errors++;
      $display("FAIL drop_after: d=%b r=%b b=%b want 0 1 0",
               drop, in_ready, busy);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (out_valid === 1'b1 || drop === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL drop_quiet: stray cycles=%0d want 0", seen);
    end
  endtask

  task automatic test_single();
    start_tri(32'h0001_0000, 32'h0005_8000, 32'h0007_8000,
              32'h7FFF_0000, 32'h0, 1'b1,
              12'd5, 12'd5, 12'd7, 12'd7);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_setup: v=%b want 0", out_valid);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_x !== 12'd5 ||
        out_y !== 12'd7 || out_p !== 32'h0001_0000 ||
        out_last !== 1'b1) begin
      errors++;
      $display("FAIL single_beat: v=%b (%0d,%0d) p=%h l=%b want 1 (5,7) p=00010000 l=1",
               out_valid, out_x, out_y, out_p, out_last);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_end: v=%b r=%b want 0 1",
               out_valid, in_ready);
    end
  endtask

  task automatic test_neg_slope();
    logic [31:0] ep;
    start_tri(32'h0001_0000, 32'h0, 32'h0,
              32'hFFFF_C000, 32'h0, 1'b1,
              12'd0, 12'd3, 12'd0, 12'd0);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: ep = 32'h0000_E000;
        1: ep = 32'h0000_A000;
        2: ep = 32'h0000_6000;
        default: ep = 32'h0000_2000;
      endcase
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_x !== 12'(k) ||
          out_y !== 12'd0 || out_p !== ep ||
          out_last !== (k == 3)) begin
        errors++;
        $display("FAIL neg_beat%0d: v=%b (%0d,%0d) p=%h l=%b want (%0d,0) p=%h",
                 k, out_valid, out_x, out_y, out_p, out_last,
                 k, ep);
      end
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL neg_end: v=%b r=%b want 0 1",
               out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    seen = 0;
    start_basic();
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_x !== 12'd1 ||
        out_p !== 32'h0002_8000) begin
      errors++;
      $display("FAIL rmid_beat1: v=%b x=%0d p=%h want 1 1 00028000",
               out_valid, out_x, out_p);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 ||
        out_p !== 32'h0) begin
      errors++;
      $display("FAIL rmid_async: v=%b b=%b p=%h want 0 0 0",
               out_valid, busy, out_p);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rmid_after: r=%b b=%b want 1 0",
               in_ready, busy);
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL rmid_residual: beats=%0d want 0", seen);
    end
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    p_ref     = '0;
    x_ref     = '0;
    y_ref     = '0;
    dpdx      = '0;
    dpdy      = '0;
    grad_ok   = 1'b0;
    bb_xmin   = '0;
    bb_xmax   = '0;
    bb_ymin   = '0;
    bb_ymax   = '0;

    e_x[0] = 12'd0; e_y[0] = 12'd0; e_p[0] = 32'h0001_8000;
    e_x[1] = 12'd1; e_y[1] = 12'd0; e_p[1] = 32'h0002_8000;
    e_x[2] = 12'd2; e_y[2] = 12'd0; e_p[2] = 32'h0003_8000;
    e_x[3] = 12'd0; e_y[3] = 12'd1; e_p[3] = 32'h0003_8000;
    e_x[4] = 12'd1; e_y[4] = 12'd1; e_p[4] = 32'h0004_8000;
    e_x[5] = 12'd2; e_y[5] = 12'd1; e_p[5] = 32'h0005_8000;

    test_reset();
    test_basic();
    test_stall();
    test_drop(1'b0, 12'd0, 12'd2);
    test_drop(1'b1, 12'd3, 12'd2);
    test_single();
    test_neg_slope();
    test_reset_mid();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/attr_span_walker.md
ATTR_SPAN_WALKER -- requirements
Module: attr_span_walker

Interface
REQ-001 SHALL have parameter INT, default 16, integer bits of the Q attribute/coordinate format.
REQ-002 SHALL have parameter FRAC, default 16, fraction bits of the Q format; Q width QW = INT+FRAC.
REQ-003 SHALL have parameter XYW, default 12, unsigned integer pixel-coordinate width.
REQ-004 SHALL have ports: clk  in  1  single clock; rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports: in_valid  in  1  triangle offered; in_ready  out  1  walker can accept.
REQ-006 SHALL have ports: p_ref, x_ref, y_ref  in  QW each, signed  attribute and position at vertex 1.
REQ-007 SHALL have ports: dpdx, dpdy  in  QW each, signed  gradients from the gradient stage; grad_ok  in  1  gradient stage valid flag.
REQ-008 SHALL have ports: bb_xmin, bb_xmax, bb_ymin, bb_ymax  in  XYW each, unsigned  inclusive pixel bounding box.
REQ-009 SHALL have ports: out_valid  out  1; out_ready  in  1; out_x, out_y  out  XYW; out_p  out  QW signed; out_last  out  1  final pixel of triangle.
REQ-010 SHALL have ports: busy  out  1  state != IDLE; drop  out  1  one-cycle pulse when a triangle produces no pixels.

Function
REQ-011 SHALL implement states IDLE, SETUP, WALK; in_ready = 1 only in IDLE.
REQ-012 Input handshake (in_valid & in_ready) SHALL register all inputs and move IDLE -> SETUP.
REQ-013 In SETUP, if grad_ok = 0 or bb_xmin > bb_xmax or bb_ymin > bb_ymax, SHALL pulse drop for one cycle and return to IDLE with no output beat.
REQ-014 Otherwise SETUP SHALL compute p_start = p_ref + dpdx*(xc - x_ref) + dpdy*(yc - y_ref), xc/yc = pixel centre of (bb_xmin, bb_ymin) = (coord << FRAC) + 2^(FRAC-1), then enter WALK.
REQ-015 Setup arithmetic: deltas QW+1 bits, products 2*QW+2 bits, sum full width, arithmetic right shift by FRAC (floor), saturate to signed QW range.
REQ-016 First out_valid SHALL assert exactly 2 cycles after the input handshake cycle.
REQ-017 WALK SHALL emit pixels in raster order: x from bb_xmin to bb_xmax, then y+1; one beat per cycle while out_ready = 1.
REQ-018 Within a row next p = p + dpdx; at row wrap next p = p_row + dpdy and p_row updated to that value; accumulators wrap two's-complement at QW bits (no saturation).
REQ-019 While out_valid = 1 and out_ready = 0, out_x, out_y, out_p, out_last SHALL hold stable; no pixel skipped or repeated.
REQ-020 out_last SHALL be 1 only with (out_x, out_y) = (bb_xmax, bb_ymax); its handshake returns to IDLE, in_ready = 1 the following cycle (no same-cycle accept).
REQ-021 out_valid SHALL be 0 in IDLE and SETUP.

Reset
REQ-022 rst SHALL asynchronously force state IDLE; out_valid, out_last, drop, busy = 0; out_x, out_y, out_p and accumulators = 0; in_ready = 1 after release.
REQ-023 rst asserted mid-SETUP or mid-WALK SHALL abandon the triangle with no further beats.

Structure
REQ-024 Shared package attr_pkg SHALL hold the INT/FRAC/QW defaults, the state enumeration, and the Q saturation limits.
REQ-025 Setup arithmetic (REQ-014/015) SHALL be a combinational sub-module attr_setup_mac; stepping, counters and FSM remain in attr_span_walker.

Verification
REQ-026 p_ref=0, x_ref=y_ref=0, dpdx=0x00010000, dpdy=0x00020000, bbox x0..2 y0..1 -> 6 beats, out_p 0x00018000, 0x00028000, 0x00038000, 0x00038000, 0x00048000, 0x00058000; out_last on (2,1) only.
REQ-027 Same as REQ-026 with out_ready low 3 cycles at the 3rd beat -> 3rd beat held constant, total 6 beats, order unchanged.
REQ-028 grad_ok=0 (any bbox) -> drop pulses once 1 cycle after handshake, no out_valid, in_ready high next cycle.
REQ-029 bbox x 5..5, y 7..7, p_ref=0x00010000, x_ref=0x00058000, y_ref=0x00078000, dpdx=0x7FFF0000 -> single beat (5,7), out_p=0x00010000, out_last=1.
REQ-030 p_ref=0x00010000, x_ref=y_ref=0, dpdx=0xFFFFC000 (-0.25), dpdy=0, bbox x0..3 y0..0 -> out_p 0x0000E000, 0x0000A000, 0x00006000, 0x00002000.
REQ-031 rst asserted during 2nd beat of REQ-026 -> out_valid 0 same cycle; after release in_ready=1, busy=0, no residual beats.
